// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write controller.
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 16;
    localparam int unsigned SPI_ADDR_W  = 7;
    localparam int unsigned SPI_DATA_W  = 8;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SCLK_HI,
        ST_SCLK_LO,
        ST_GAP
    } spi_state_e;

    typedef struct packed {
        logic                  rw;
        logic [SPI_ADDR_W-1:0] addr;
        logic [SPI_DATA_W-1:0] data;
    } spi_frame_t;

endpackage

// File: rtl/spi_sclk_timer.sv
// Phase down-counter: reloads to HALF_DIV-1 on load or on expiry, flags the last cycle of a phase.
module spi_sclk_timer #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(HALF_DIV) + 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || cnt == '0) begin
            cnt <= CNT_W'(HALF_DIV - 1);
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire_c = (cnt == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 frame master sending {rw, addr, wdata} MSB first.
// Optional read-back path (CIPO/rdata) enabled by defining SPI_CTRL_READ_EN.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SPI_ADDR_W-1:0] addr,
    input  logic [SPI_DATA_W-1:0] wdata,
`ifdef SPI_CTRL_READ_EN
    input  logic                  CIPO,
    output logic [SPI_DATA_W-1:0] rdata,
`endif
    output logic                  ready,
    output logic                  done,
    output logic                  SCLK,
    output logic                  nCS,
    output logic                  COPI
);

    if (HALF_DIV < 3) begin : g_div_check
        $error("spi_controller: HALF_DIV must be at least 3");
    end

    spi_state_e             state;
    logic [SPI_FRAME_W-1:0] shreg;
    logic [4:0]             bit_cnt;
    logic                   accept_c;
    logic                   expire_c;
    spi_frame_t             frame_c;

    assign accept_c = (state == ST_IDLE) && start;
    assign frame_c  = '{rw: rw, addr: addr, data: wdata};

    spi_sclk_timer #(.HALF_DIV(HALF_DIV)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_c),
        .expire_c (expire_c)
    );

`ifdef SPI_CTRL_READ_EN
    logic [SPI_DATA_W-1:0] rx_sh;
`endif

    // Frame sequencer; the shift register rotates so its contents stay intact until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            SCLK    <= 1'b0;
            nCS     <= 1'b1;
            COPI    <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            rx_sh   <= '0;
            rdata   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= frame_c;
                        bit_cnt <= '0;
                        ready   <= 1'b0;
                        nCS     <= 1'b0;
                        SCLK    <= 1'b0;
                        COPI    <= frame_c.rw;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (expire_c) begin
                        SCLK  <= 1'b1;
                        state <= ST_SCLK_HI;
                    end
                end
                ST_SCLK_HI: begin
                    if (expire_c) begin
                        SCLK    <= 1'b0;
                        COPI    <= shreg[SPI_FRAME_W-2];
                        shreg   <= {shreg[SPI_FRAME_W-2:0], shreg[SPI_FRAME_W-1]};
                        bit_cnt <= bit_cnt + 5'd1;
                        state   <= ST_SCLK_LO;
                    end
                end
                ST_SCLK_LO: begin
                    if (expire_c) begin
                        if (bit_cnt < 5'(SPI_FRAME_W)) begin
                            SCLK  <= 1'b1;
                            state <= ST_SCLK_HI;
`ifdef SPI_CTRL_READ_EN
                            // Peripheral answers during the data byte: rises 9..16.
                            if (bit_cnt >= 5'(SPI_FRAME_W - SPI_DATA_W)) begin
                                rx_sh <= {rx_sh[SPI_DATA_W-2:0], CIPO};
                            end
`endif
                        end else begin
                            nCS   <= 1'b1;
                            COPI  <= 1'b0;
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (expire_c) begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= ST_IDLE;
`ifdef SPI_CTRL_READ_EN
                        rdata <= rx_sh;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    nCS   <= 1'b1;
                    SCLK  <= 1'b0;
                    COPI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller (HALF_DIV=4): stimulus queues expected frames, a monitor checks them at done.
module tb_spi_controller;

    localparam int unsigned HALF_DIV = 4;
    localparam int unsigned LATENCY  = 137;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       done;
    logic       sclk;
    logic       ncs;
    logic       copi;
`ifdef SPI_CTRL_READ_EN
    logic       cipo = 1'b0;
    logic [7:0] rdata;
    logic [7:0] rd_pat = 8'hA5;
`endif

    spi_controller #(.HALF_DIV(HALF_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
`ifdef SPI_CTRL_READ_EN
        .CIPO  (cipo),
        .rdata (rdata),
`endif
        .ready (ready),
        .done  (done),
        .SCLK  (sclk),
        .nCS   (ncs),
        .COPI  (copi)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] exp_q[$];
    int          done_cnt   = 0;
    int          acc_cnt    = 0;
    int          total_rise = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: rebuilds each frame from COPI at SCLK rises and scores it when done pulses.
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          nrise   = 0;
    int          hi_run  = 0;
    bit          have_prev = 1'b0;
    logic        sclk_q  = 1'b0;
    logic        ncs_q   = 1'b1;
    logic [15:0] bits    = '0;
    logic [15:0] want;
    logic [7:0]  pregs [128] = '{default: 8'h00};

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            have_prev = 1'b0;
            hi_run    = 0;
            nrise     = 0;
            sclk_q    = 1'b0;
            ncs_q     = 1'b1;
        end else begin
            if (done) begin
                check("done_with_ready", 32'(ready), 32'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_done: got frame 0x%0h, expected no frame", bits);
                end else begin
                    want = exp_q.pop_front();
                    check("frame_bits", 32'(bits), 32'(want));
                    check("sclk_rises", 32'(nrise), 32'd16);
                    check("latency", 32'(cyc - acc_cyc), 32'(LATENCY));
                end
                if (bits[15]) pregs[bits[14:8]] = bits[7:0];
`ifdef SPI_CTRL_READ_EN
                check("rdata", 32'(rdata), 32'h0000_00A5);
`endif
                done_cnt++;
            end
            if (ready && start) begin
                acc_cnt++;
                acc_cyc = cyc;
                nrise   = 0;
                bits    = '0;
            end
            if (sclk && !sclk_q) begin
                bits = {bits[14:0], copi};
                nrise++;
                total_rise++;
            end
`ifdef SPI_CTRL_READ_EN
            cipo = (nrise >= 8 && nrise < 16) ? rd_pat[15 - nrise] : 1'b0;
`endif
            if (ncs) begin
                hi_run++;
            end else if (ncs_q) begin
                if (have_prev) begin
                    n_vec++;
                    if (hi_run < int'(HALF_DIV + 1)) begin
                        n_miss++;
                        $display("FAIL ncs_gap: got %0d cycles high, expected at least %0d", hi_run, HALF_DIV + 1);
                    end
                end
                have_prev = 1'b1;
                hi_run    = 0;
            end
            sclk_q = sclk;
            ncs_q  = ncs;
        end
    end

    task automatic wait_acc(input int target);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (acc_cnt >= target) break;
        end
        check("accept_count", 32'(acc_cnt), 32'(target));
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        check("done_count", 32'(done_cnt), 32'(target));
    endtask

    task automatic set_frame(input logic r, input logic [6:0] a, input logic [7:0] d);
        rw    = r;
        addr  = a;
        wdata = d;
    endtask

    int rise_base;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        set_frame(1'b1, 7'h04, 8'h80);
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ncs",   32'(ncs),   32'd1);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_copi",  32'(copi),  32'd0);
        check("rst_done",  32'(done),  32'd0);

        // Frame A accepted on the first edge after reset release; two stray starts mid-frame.
        exp_q.push_back(16'h8480);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_acc(1);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 begin start = 1'b1; set_frame(1'b1, 7'h7F, 8'h55); end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (49) @(posedge clk);
        #1 begin start = 1'b1; set_frame(1'b0, 7'h33, 8'hAA); end
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1, 200);
        repeat (10) @(posedge clk);
        check("single_frame_done", 32'(done_cnt), 32'd1);

        // Start held high: frames B then C back to back.
        rise_base = total_rise;
        exp_q.push_back(16'h553C);
        exp_q.push_back(16'h91C3);
        #1 begin start = 1'b1; set_frame(1'b0, 7'h55, 8'h3C); end
        wait_acc(2);
        #1 set_frame(1'b1, 7'h11, 8'hC3);
        wait_acc(3);
        #1 start = 1'b0;
        wait_done(3, 400);
        check("held_rises", 32'(total_rise - rise_base), 32'd32);

        // Frame D aborted by reset after the 7th SCLK rise; must not complete.
        repeat (3) @(posedge clk);
        rise_base = total_rise;
        #1 begin start = 1'b1; set_frame(1'b1, 7'h04, 8'h00); end
        wait_acc(4);
        #1 start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (total_rise >= rise_base + 7) break;
        end
        check("abort_rises", 32'(total_rise - rise_base), 32'd7);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ncs",   32'(ncs),   32'd1);
        check("abort_sclk",  32'(sclk),  32'd0);
        check("abort_copi",  32'(copi),  32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done",  32'(done),  32'd0);

        // Frame E right after reset release: write 0xFF to register 0x02.
        repeat (3) @(posedge clk);
        #1 begin start = 1'b1; set_frame(1'b1, 7'h02, 8'hFF); end
        exp_q.push_back(16'h82FF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_acc(5);
        #1 start = 1'b0;
        wait_done(4, 200);
        repeat (20) @(posedge clk);

        check("reg_02",      32'(pregs[7'h02]), 32'h0000_00FF);
        check("reg_04",      32'(pregs[7'h04]), 32'h0000_0080);
        check("reg_11",      32'(pregs[7'h11]), 32'h0000_00C3);
        check("reg_55",      32'(pregs[7'h55]), 32'h0000_0000);
        check("final_done",  32'(done_cnt),     32'd4);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_ncs",   32'(ncs),          32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000 time units, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter HALF_DIV, default 4, clk cycles per SCLK half-period; values below 3 SHALL cause an elaboration error.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a frame; sampled only while ready=1.
REQ-005 SHALL have port rw  input  1  frame R/W bit; 1=write, 0=read; captured with start.
REQ-006 SHALL have port addr  input  7  register address; captured with start.
REQ-007 SHALL have port wdata  input  8  write data; captured with start.
REQ-008 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port SCLK  output  1  serial clock, SPI mode 0, idle low.
REQ-011 SHALL have port nCS  output  1  chip select, active-low, idle high.
REQ-012 SHALL have port COPI  output  1  serial data to peripheral, MSB first.

Function
REQ-013 SHALL send 16-bit frame {rw, addr[6:0], wdata[7:0]}, bit 15 first.
REQ-014 SHALL implement states IDLE, SETUP, SCLK_HI, SCLK_LO, GAP.
REQ-015 SHALL in IDLE with start=1 latch rw/addr/wdata into a 16-bit shift register, clear the 5-bit bit counter, and enter SETUP next cycle.
REQ-016 SHALL in SETUP drive nCS=0, SCLK=0, COPI=frame bit 15 for HALF_DIV cycles, then enter SCLK_HI.
REQ-017 SHALL in SCLK_HI drive SCLK=1 for HALF_DIV cycles with COPI stable, then enter SCLK_LO and increment the bit counter.
REQ-018 SHALL on entry to SCLK_LO shift COPI to the next bit; after HALF_DIV cycles SHALL return to SCLK_HI if counter<16, else enter GAP.
REQ-019 SHALL in GAP drive nCS=1, SCLK=0, COPI=0 for HALF_DIV cycles, then pulse done=1 for one cycle and return to IDLE.
REQ-020 SHALL generate exactly 16 SCLK rising edges per frame; total frame is 1+34*HALF_DIV cycles from start acceptance to done.
REQ-021 SHALL drive ready=1 only in IDLE; done and ready SHALL be high in the same cycle.
REQ-022 SHALL ignore start, rw, addr, wdata while ready=0; captured frame SHALL not change mid-transfer.
REQ-023 SHALL accept start in the same cycle ready rises, allowing back-to-back frames with nCS high for at least HALF_DIV+1 cycles between them.
REQ-024 SHALL use one down-counter of width clog2(HALF_DIV)+1 for all phase timing.
REQ-025 SHALL register all SPI outputs (no combinational glitches on SCLK/nCS/COPI).

Reset
REQ-026 SHALL on rst_n=0, including mid-frame, immediately force state=IDLE, nCS=1, SCLK=0, COPI=0, done=0, ready=1, counters and shift register=0.
REQ-027 SHALL accept start on the first clk edge after rst_n deasserts.

Configuration
REQ-028 With SPI_CTRL_READ_EN defined, SHALL add ports CIPO input 1 and rdata output 8, sample CIPO on the clk cycle of each of the last 8 SCLK rising edges, and load rdata at done (rdata reset 0, held otherwise).
REQ-029 Without SPI_CTRL_READ_EN, CIPO and rdata SHALL not exist and no sampling logic SHALL be built.

Structure
REQ-030 SHALL place the state enum, SPI_FRAME_W=16, SPI_ADDR_W=7, SPI_DATA_W=8 and the R/W encoding constants in shared package spi_pkg.
REQ-031 SHALL instantiate one sub-module spi_sclk_timer (phase down-counter, expiry pulse); all else inline.

Verification
REQ-032 Write rw=1 addr=0x04 wdata=0x80, HALF_DIV=4 -> COPI bits at 16 SCLK rises = 1_0000100_10000000, done 137 cycles after acceptance.
REQ-033 start pulsed 10 and 60 cycles after first acceptance -> both ignored, exactly one frame, one done.
REQ-034 start held high -> two frames, nCS high at least 5 cycles between them, 32 SCLK rises total.
REQ-035 rst_n low after 7th SCLK rise -> nCS=1, SCLK=0 immediately; next frame after reset is complete and correct.
REQ-036 Loopback to team spi_peripheral: write addr 0x02 data 0xFF -> en_reg_pwm_7_0=0xFF, other registers unchanged.
REQ-037 With SPI_CTRL_READ_EN, CIPO model returns 0xA5 -> rdata=0xA5 in the done cycle.
